// File: rtl/lbp_pkg.sv
// Shared types and constants for the streaming LBP engine.
package lbp_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } lbp_state_t;

    // Bit positions of each neighbour inside the 8-bit LBP code.
    localparam logic [2:0] NB_TL = 3'd0;
    localparam logic [2:0] NB_T  = 3'd1;
    localparam logic [2:0] NB_TR = 3'd2;
    localparam logic [2:0] NB_L  = 3'd3;
    localparam logic [2:0] NB_R  = 3'd4;
    localparam logic [2:0] NB_BL = 3'd5;
    localparam logic [2:0] NB_B  = 3'd6;
    localparam logic [2:0] NB_BR = 3'd7;

    // Width of a {row, col} pixel address.
    function automatic int unsigned lbp_addr_w(input int unsigned w_log2,
                                               input int unsigned h_log2);
        return w_log2 + h_log2;
    endfunction

endpackage

// File: rtl/lbp_stream_if.sv
// Gray-memory read port and LBP-memory write port of the LBP engine.
interface lbp_stream_if #(
    parameter int unsigned AW    = 14,
    parameter int unsigned PIX_W = 8
);
    logic [AW-1:0]    gray_addr;
    logic             gray_req;
    logic             gray_ready;
    logic [PIX_W-1:0] gray_data;
    logic [PIX_W-1:0] thr;
    logic [AW-1:0]    lbp_addr;
    logic             lbp_valid;
    logic [7:0]       lbp_data;
    logic             finish;

    // Engine side.
    modport master (
        output gray_addr, gray_req,
        input  gray_ready, gray_data, thr,
        output lbp_addr, lbp_valid, lbp_data, finish
    );

    // Memory / environment side.
    modport slave (
        input  gray_addr, gray_req,
        output gray_ready, gray_data, thr,
        input  lbp_addr, lbp_valid, lbp_data, finish
    );
endinterface

// File: rtl/lbp_line_buffer.sv
// One image row of delay: output is the sample written 2^DEPTH_LOG2 enables ago.
module lbp_line_buffer #(
    parameter int unsigned DEPTH_LOG2 = 7,
    parameter int unsigned PIX_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_data,
    output logic [PIX_W-1:0] o_data
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [PIX_W-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_ptr;

    // Circular pointer; advances only when a new pixel is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + DEPTH_LOG2'(1);
        end
    end

    // Storage is not reset; stale contents only ever reach border results.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    // The slot about to be overwritten holds the oldest sample.
    assign o_data = r_mem[r_ptr];

endmodule

// File: rtl/lbp_stream.sv
// Streaming 3x3 Local Binary Pattern engine: reads a gray frame once in raster
// order and writes one LBP code per pixel, borders forced to zero.
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int unsigned IMG_W_LOG2 = 7,
    parameter int unsigned IMG_H_LOG2 = 7,
    parameter int unsigned PIX_W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    lbp_stream_if.master bus
);
    localparam int unsigned AW          = lbp_addr_w(IMG_W_LOG2, IMG_H_LOG2);
    localparam int unsigned W           = 1 << IMG_W_LOG2;
    localparam logic [AW-1:0] LAST_ADDR   = '1;
    localparam logic [AW-1:0] FIRST_RES_K = AW'(W + 1);

    lbp_state_t        r_state;
    lbp_state_t        w_state_next;

    logic              r_req;
    logic [AW-1:0]     r_gaddr;
    logic [PIX_W-1:0]  r_thr;
    logic              r_rx_valid;
    logic [AW-1:0]     r_k;
    logic [AW-1:0]     r_j;

    logic              r_lbp_valid;
    logic [AW-1:0]     r_lbp_addr;
    logic [7:0]        r_lbp_data;
    logic              r_finish;

    logic              w_xfer;
    logic [PIX_W-1:0]  w_lb_mid;
    logic [PIX_W-1:0]  w_lb_top;
    logic [PIX_W-1:0]  r_win    [3][3];
    logic [PIX_W-1:0]  w_win_nx [3][3];
    logic [PIX_W:0]    w_cthr;
    logic [7:0]        w_code;
    logic [IMG_H_LOG2-1:0] w_row;
    logic [IMG_W_LOG2-1:0] w_col;
    logic              w_border;

    assign w_xfer = (r_state == STREAM) && r_req && bus.gray_ready;

    assign bus.gray_addr = r_gaddr;
    assign bus.gray_req  = r_req;
    assign bus.lbp_addr  = r_lbp_addr;
    assign bus.lbp_valid = r_lbp_valid;
    assign bus.lbp_data  = r_lbp_data;
    assign bus.finish    = r_finish;

    // Previous row (k-W) and the row before it (k-2W).
    lbp_line_buffer #(
        .DEPTH_LOG2 (IMG_W_LOG2),
        .PIX_W      (PIX_W)
    ) u_lb_mid (
        .clk    (clk),
        .reset  (reset),
        .i_en   (r_rx_valid),
        .i_data (bus.gray_data),
        .o_data (w_lb_mid)
    );

    lbp_line_buffer #(
        .DEPTH_LOG2 (IMG_W_LOG2),
        .PIX_W      (PIX_W)
    ) u_lb_top (
        .clk    (clk),
        .reset  (reset),
        .i_en   (r_rx_valid),
        .i_data (w_lb_mid),
        .o_data (w_lb_top)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.gray_ready) w_state_next = STREAM;
            STREAM:  if (r_rx_valid && (r_k == LAST_ADDR)) w_state_next = FLUSH;
            FLUSH:   if (r_j == LAST_ADDR) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Window after shifting in the column that ends at the newly received pixel.
    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            w_win_nx[r][0] = r_win[r][1];
            w_win_nx[r][1] = r_win[r][2];
        end
        w_win_nx[0][2] = w_lb_top;
        w_win_nx[1][2] = w_lb_mid;
        w_win_nx[2][2] = bus.gray_data;
    end

    // Window registers; frozen while no pixel arrives.
    always_ff @(posedge clk) begin
        if (r_rx_valid) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    r_win[r][c] <= w_win_nx[r][c];
                end
            end
        end
    end

    // Neighbour compares against centre+threshold, one bit wider so it cannot wrap.
    always_comb begin
        w_cthr = {1'b0, w_win_nx[1][1]} + {1'b0, r_thr};
        w_code = '0;
        w_code[NB_TL] = ({1'b0, w_win_nx[0][0]} >= w_cthr);
        w_code[NB_T]  = ({1'b0, w_win_nx[0][1]} >= w_cthr);
        w_code[NB_TR] = ({1'b0, w_win_nx[0][2]} >= w_cthr);
        w_code[NB_L]  = ({1'b0, w_win_nx[1][0]} >= w_cthr);
        w_code[NB_R]  = ({1'b0, w_win_nx[1][2]} >= w_cthr);
        w_code[NB_BL] = ({1'b0, w_win_nx[2][0]} >= w_cthr);
        w_code[NB_B]  = ({1'b0, w_win_nx[2][1]} >= w_cthr);
        w_code[NB_BR] = ({1'b0, w_win_nx[2][2]} >= w_cthr);
    end

    // r_j is the centre of the result being produced; edges also mask wrap garbage.
    assign w_row    = r_j[AW-1:IMG_W_LOG2];
    assign w_col    = r_j[IMG_W_LOG2-1:0];
    assign w_border = (w_row == '0) || (w_row == '1) || (w_col == '0) || (w_col == '1);

    // Read addressing, pixel counting and result/finish registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req       <= 1'b0;
            r_gaddr     <= '0;
            r_thr       <= '0;
            r_rx_valid  <= 1'b0;
            r_k         <= '0;
            r_j         <= '0;
            r_lbp_valid <= 1'b0;
            r_lbp_addr  <= '0;
            r_lbp_data  <= '0;
            r_finish    <= 1'b0;
        end else begin
            r_lbp_valid <= 1'b0;
            r_finish    <= 1'b0;
            r_rx_valid  <= w_xfer;
            unique case (r_state)
                IDLE: begin
                    if (bus.gray_ready) begin
                        r_req   <= 1'b1;
                        r_gaddr <= '0;
                        r_thr   <= bus.thr;
                        r_k     <= '0;
                        r_j     <= '0;
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        r_gaddr <= r_gaddr + AW'(1);
                        if (r_gaddr == LAST_ADDR) begin
                            r_req <= 1'b0;
                        end
                    end
                    if (r_rx_valid) begin
                        r_k <= r_k + AW'(1);
                        if (r_k >= FIRST_RES_K) begin
                            r_lbp_valid <= 1'b1;
                            r_lbp_addr  <= r_j;
                            r_lbp_data  <= w_border ? 8'h00 : w_code;
                            r_j         <= r_j + AW'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Last W+1 centres all sit on the border.
                    r_lbp_valid <= 1'b1;
                    r_lbp_addr  <= r_j;
                    r_lbp_data  <= 8'h00;
                    r_j         <= r_j + AW'(1);
                end
                DONE: begin
                    r_finish <= 1'b1;
                end
                default: begin
                    r_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_stream.sv
// Bench for lbp_stream on an 8x8 frame: gray memory model, reference LBP model,
// result scoreboard and frame timing checks.
module tb_lbp_stream;
    localparam int WL = 3;
    localparam int HL = 3;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = 64;
    localparam int PW = 8;
    localparam int AW = 6;

    typedef struct {
        int addr;
        int code;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lbp_stream_if #(.AW(AW), .PIX_W(PW)) bus();

    lbp_stream #(
        .IMG_W_LOG2 (WL),
        .IMG_H_LOG2 (HL),
        .PIX_W      (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int img [N];
    int got [N];
    exp_t exp_q [$];
    exp_t e;
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    int cyc = 0;
    int n_wr, n_fin, first_valid_cyc, last_wr_cyc, finish_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: LBP of every pixel straight from the image definition.
    task automatic build_exp(input int thr_v);
        exp_q.delete();
        for (int j = 0; j < N; j++) begin
            int r, c, code;
            exp_t x;
            r = j / W;
            c = j % W;
            code = 0;
            if (r != 0 && r != H - 1 && c != 0 && c != W - 1) begin
                for (int b = 0; b < 8; b++) begin
                    if (img[(r + dr[b]) * W + (c + dc[b])] >= img[j] + thr_v)
                        code += (1 << b);
                end
            end
            x.addr = j;
            x.code = code;
            exp_q.push_back(x);
        end
        for (int j = 0; j < N; j++) got[j] = -1;
    endtask

    // Result monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.lbp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lbp_addr", int'(bus.lbp_addr), e.addr);
                    chk("lbp_data", int'(bus.lbp_data), e.code);
                end
                got[bus.lbp_addr] = int'(bus.lbp_data);
                if (n_wr == 0) first_valid_cyc = cyc;
                n_wr++;
                last_wr_cyc = cyc;
            end
            if (bus.finish) begin
                n_fin++;
                finish_cyc = cyc;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_gray_addr"}, int'(bus.gray_addr), 0);
        chk({tag, "_gray_req"},  int'(bus.gray_req), 0);
        chk({tag, "_lbp_addr"},  int'(bus.lbp_addr), 0);
        chk({tag, "_lbp_valid"}, int'(bus.lbp_valid), 0);
        chk({tag, "_lbp_data"},  int'(bus.lbp_data), 0);
        chk({tag, "_finish"},    int'(bus.finish), 0);
    endtask

    // Drives one frame: memory responses, ready pattern, optional abort by reset.
    task automatic run_frame(input int thr_v, input int stall_len, input int rnd_pct,
                             input int abort_at);
        bit pend, done, aborted, rdy;
        int pend_addr, stalled, n_stall, first_x;
        build_exp(thr_v);
        n_wr = 0; n_fin = 0;
        pend = 0; done = 0; aborted = 0;
        pend_addr = 0; stalled = 0; n_stall = 0; first_x = -1;
        bus.thr = PW'(thr_v);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (abort_at >= 0 && bus.lbp_valid && int'(bus.lbp_addr) == abort_at) begin
                #2 reset = 1'b1;
                #1 check_outputs_zero("abort");
                exp_q.delete();
                @(negedge clk);
                bus.gray_ready = 1'b0;
                reset = 1'b0;
                aborted = 1;
                done = 1;
            end else if (bus.finish) begin
                bus.gray_ready = 1'b0;
                done = 1;
            end else begin
                if (pend) bus.gray_data = PW'(img[pend_addr]);
                rdy = 1;
                if (stall_len > 0 && stalled > 0 && stalled < stall_len) begin
                    rdy = 0;
                    stalled++;
                    chk("stall_addr_hold", int'(bus.gray_addr), 20);
                end else if (stall_len > 0 && stalled == 0 && bus.gray_req &&
                             int'(bus.gray_addr) == 20) begin
                    rdy = 0;
                    stalled++;
                end else if (rnd_pct > 0 && first_x >= 0 &&
                             $urandom_range(0, 99) < rnd_pct) begin
                    rdy = 0;
                end
                bus.gray_ready = rdy;
                if (first_x >= 0 && bus.gray_req && !rdy) n_stall++;
                pend = bus.gray_req && rdy;
                pend_addr = int'(bus.gray_addr);
                if (pend && first_x < 0) begin
                    first_x = cyc;
                    bus.thr = PW'(thr_v ^ 8'h5A);
                end
            end
        end
        chk("frame_terminated", int'(done), 1);
        if (done && !aborted) begin
            @(negedge clk);
            chk("finish_width", int'(bus.finish), 0);
            chk("write_count", n_wr, N);
            chk("finish_count", n_fin, 1);
            chk("results_pending", exp_q.size(), 0);
            chk("finish_after_last_write", finish_cyc - last_wr_cyc, 1);
            chk("frame_cycles", finish_cyc - first_x, N + W + 3 + n_stall);
            if (n_stall == 0) chk("first_valid_latency", first_valid_cyc - first_x, W + 3);
        end
    endtask

    task automatic fill_const(input int v);
        for (int j = 0; j < N; j++) img[j] = v;
    endtask

    task automatic fill_ramp();
        for (int j = 0; j < N; j++) img[j] = (j % W) * 10;
    endtask

    initial begin
        reset = 1'b1;
        bus.gray_ready = 1'b0;
        bus.gray_data = '0;
        bus.thr = '0;
        n_wr = 0; n_fin = 0;
        first_valid_cyc = 0; last_wr_cyc = 0; finish_cyc = 0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        fill_const(50);
        run_frame(0, 0, 0, -1);
        chk("const_interior", got[9], 8'hFF);
        chk("const_border", got[0], 0);

        fill_ramp();
        run_frame(0, 0, 0, -1);
        chk("ramp_interior", got[10], 8'hD6);

        fill_const(50);
        run_frame(5, 0, 0, -1);
        chk("const_thr5", got[9], 0);

        fill_ramp();
        run_frame(0, 3, 0, -1);

        fill_ramp();
        run_frame(0, 0, 0, 30);
        run_frame(0, 0, 0, -1);
        chk("after_abort_interior", got[10], 8'hD6);

        fill_const(255);
        img[27] = 250;
        run_frame(10, 0, 0, -1);
        chk("no_wrap_thr10", got[27], 0);
        run_frame(5, 0, 0, -1);
        chk("no_wrap_thr5", got[27], 8'hFF);

        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < N; j++) img[j] = $urandom_range(0, 255);
            run_frame($urandom_range(0, 40), 0, 20, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
